// File: rtl/multiply_num.sv
// multiply_num: sequential shift-add multiplier, product = multiplicand*multiplier + addend, one step per clock
module multiply_num #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   input  logic [N-1:0]   addend,
   output logic [2*N-1:0] product,
   output logic           fits_n,
   output logic           checkflag,
   output logic           busy
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;
   logic [2*N-1:0] acc, mcand, acc_nx;
   logic [N-1:0] mplier;
   logic [CW-1:0] count;
   assign acc_nx = mplier[0] ? acc + mcand : acc;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
         product   <= '0;
         fits_n    <= 1'b0;
         checkflag <= 1'b0;
         busy      <= 1'b0;
      end else
         case (state)
            IDLE:
               if (enable) begin
                  acc    <= {{N{1'b0}}, addend};
                  mcand  <= {{N{1'b0}}, multiplicand};
                  mplier <= multiplier;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            CALC:
               if (!enable) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc    <= acc_nx;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
                  if (count == LAST) begin
                     product   <= acc_nx;
                     fits_n    <= acc_nx[2*N-1:N] == '0;
                     checkflag <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end
               end
            DONE:
               if (!enable) begin
                  checkflag <= 1'b0;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_multiply_num.sv
// tb_multiply_num: directed and random checks of multiply_num against a plain arithmetic model
module tb_multiply_num;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] multiplicand = '0, multiplier = '0, addend = '0;
   logic [31:0] product;
   logic        fits_n, checkflag, busy;
   int total = 0, bad = 0;

   multiply_num #(.N(16)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
      .product(product), .fits_n(fits_n), .checkflag(checkflag), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [15:0] a, b, c);
      return {16'b0, a} * {16'b0, b} + {16'b0, c};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] a, b, c);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      enable       = 1'b1;
   endtask

   task automatic wait_done(output int edges, output int busyc);
      edges = 0;
      busyc = 0;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (busy) busyc++;
      end while (!checkflag && edges < 40);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, b, c);
      int e, bc;
      logic [31:0] x;
      x = model(a, b, c);
      start_op(a, b, c);
      wait_done(e, bc);
      check({tag, "_edges"}, e, 17);
      check({tag, "_busy"}, bc, 16);
      check({tag, "_prod"}, product, x);
      check({tag, "_fits"}, {31'b0, fits_n}, {31'b0, x[31:16] == 16'h0});
   endtask

   task automatic finish_op(input logic [31:0] keep);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("drop_cf", {31'b0, checkflag}, 0);
      check("drop_keep", product, keep);
   endtask

   initial begin
      logic [31:0] prev, x;
      logic [15:0] a, b, c;
      repeat (2) @(negedge clk);
      check("rst_prod", product, 0);
      check("rst_cf", {31'b0, checkflag}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_fits", {31'b0, fits_n}, 0);
      reset = 1'b0;

      run_op("inv", 16'd150, 16'd384, 16'd0);
      check("inv_abs", product, 32'd57600);
      finish_op(32'd57600);

      run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF);
      check("max_abs", product, 32'hFFFF0000);
      check("max_cf", {31'b0, checkflag}, 1);
      finish_op(32'hFFFF0000);

      run_op("zero", 16'd0, 16'd1234, 16'd77);
      check("zero_abs", product, 32'd77);
      finish_op(32'd77);
      run_op("mzero", 16'd1, 16'd0, 16'd0);
      check("mzero_abs", product, 32'd0);
      finish_op(32'd0);

      prev = '0;
      for (int i = 0; i < 12; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         c = 16'($urandom);
         if (i == 0) b = 16'($urandom_range(0, 3));
         prev = model(a, b, c);
         run_op("rand", a, b, c);
         finish_op(prev);
      end

      start_op(16'd100, 16'd5, 16'd3);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("abort_pre_cf", {31'b0, checkflag}, 0);
      end
      enable = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'b0, busy}, 0);
      check("abort_keep", product, prev);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("abort_cf", {31'b0, checkflag}, 0);
      end
      run_op("restart", 16'd100, 16'd5, 16'd3);
      check("restart_abs", product, 32'd503);
      finish_op(32'd503);

      start_op(16'd150, 16'd384, 16'd0);
      repeat (6) @(posedge clk);
      #2;
      reset = 1'b1;
      enable = 1'b0;
      #1;
      check("mrst_prod", product, 0);
      check("mrst_cf", {31'b0, checkflag}, 0);
      check("mrst_busy", {31'b0, busy}, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_busy", {31'b0, busy}, 0);
         check("idle_cf", {31'b0, checkflag}, 0);
      end

      x = model(16'd3000, 16'd7, 16'd5);
      run_op("hold", 16'd3000, 16'd7, 16'd5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 5) begin
            multiplicand = 16'h1234;
            multiplier   = 16'h5678;
            addend       = 16'h9ABC;
         end
         check("hold_prod", product, x);
         check("hold_cf", {31'b0, checkflag}, 1);
      end
      finish_op(x);
      run_op("b2b", 16'd65535, 16'd1, 16'd0);
      check("b2b_abs", product, 32'd65535);
      check("b2b_fits", {31'b0, fits_n}, 1);
      finish_op(32'd65535);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multiply_num.md
Name: multiply_num

Overview:
- Sequential shift-add multiplier computing product = multiplicand × multiplier + addend. It is the inverse direction of the DivideNum divider.
- Used in the matching datapath to rebuild a dividend from a quotient, divisor and remainder, for self-check and score rescaling.
- Uses the same enable/checkflag handshake style as DivideNum. Takes one partial-product step per clock, N steps per operation.

Parameters:
- N, 16, operand width in bits; product width is 2N.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- enable  input  1  level request; held high for the whole operation and until checkflag is seen
- multiplicand  input  N  unsigned operand A (e.g. divisor)
- multiplier  input  N  unsigned operand B (e.g. quotient)
- addend  input  N  unsigned value added to A×B (e.g. remainder)
- product  output  2N  registered result A×B+C
- fits_n  output  1  high when product[2N-1:N] == 0, i.e. the result fits in N bits; valid with checkflag
- checkflag  output  1  result valid / operation complete
- busy  output  1  high while in CALC

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All flops clear immediately on reset assertion.
- Reset values: product=0, fits_n=0, checkflag=0, busy=0, state=IDLE, step counter=0, internal registers=0.
- Inputs are sampled only at operation start. Changes to multiplicand, multiplier or addend after start are ignored.

State machine: IDLE, CALC, DONE.
- IDLE:
  - enable==1 at a rising edge: latch acc = {N'b0, addend}, mcand = {N'b0, multiplicand}, mplier = multiplier, count = 0.
  - Set busy=1 and go to CALC.
  - checkflag stays 0 during IDLE.
- CALC: each rising edge performs one step.
  - If mplier[0]==1, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, count += 1.
  - The step with count == N-1 is the last step. On that edge: product <= final acc, fits_n <= (final acc[2N-1:N] == 0), checkflag <= 1, busy <= 0, state <= DONE.
  - enable==0 at any CALC edge: abort. Go to IDLE, busy=0, checkflag stays 0, product and fits_n keep their previous values.
- DONE:
  - checkflag, product and fits_n are held stable while enable==1.
  - enable==0 at an edge: checkflag <= 0, go to IDLE. product and fits_n are retained until the next completion.
  - A new operation requires enable to be low for at least one edge; there is no re-trigger from DONE.
- Latency: the start edge is edge 0. checkflag is high after edge N, so the result is visible N cycles after the start edge and N+1 edges from the first edge enable is seen high. For N=16 that is 17 edges.
- No early termination on mplier==0; latency is fixed at N steps.
- Arithmetic: unsigned only, 2N-bit accumulator, no overflow possible. The maximum result (2^N-1)² + (2^N-1) = 2^2N - 2^N < 2^2N.
- Simultaneous reset and enable: reset wins.
- Reset mid-CALC or in DONE: all outputs go to their reset values asynchronously. After deassertion the block is in IDLE and starts a new operation only on an enable edge.

Test Plan:
- Inverse of the DivideNum case: multiplicand=150, multiplier=384, addend=0, enable held high. Require product=57600, fits_n=1, checkflag rising exactly 17 edges after enable first sampled high, busy high for 16 cycles.
- Maximum operands: multiplicand=multiplier=addend=16'hFFFF. Require product=32'hFFFF0000, fits_n=0, checkflag=1.
- Zero and addend-only: multiplicand=0, multiplier=1234, addend=77. Require product=77 and fits_n=1 after the full 17 edges (no early finish). Then multiplicand=1, multiplier=0, addend=0. Require product=0.
- Abort: start 100×5+3, drop enable after 8 CALC edges. Require busy=0 next edge, checkflag never asserted, product unchanged from the prior result. Restart 100×5+3. Require product=503.
- Reset mid-operation: start 57600-style operands, assert reset after 5 CALC edges. Require product=0, checkflag=0 and busy=0 immediately, without waiting for a clock edge. After release with enable low, require the block to stay idle.
- Hold and back-to-back: hold enable 10 extra cycles in DONE, then change the operand inputs. Require product stable and checkflag=1 throughout. Drop enable for 1 cycle, raise it with 65535×1+0. Require product=65535, fits_n=1, checkflag low in between.
